logic_reduce_unit: RTL and testbench
====================================

Name: logic_reduce_unit

Overview:
- Parametrised, registered successor to the single-bit two-input AND gate.
- Takes a stream of WIDTH-bit operand pairs (a, b) under a valid/ready handshake.
- Applies a selectable bitwise operation (AND/OR/XOR/NAND) to each pair and reduces the per-beat results over a frame delimited by in_last.
- Presents one registered result per frame, with beat count and zero flag; sits between operand sources and downstream decision logic.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1)
- CNT_W, 8, width of the beat counter; count saturates at 2^CNT_W-1

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  unit can accept a beat
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  2  00 AND, 01 OR, 10 XOR, 11 NAND; sampled on first beat of frame
- in_last  input  1  beat is final beat of frame
- out_valid  output  1  frame result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  reduced frame result
- out_count  output  CNT_W  beats in frame, saturating
- out_zero  output  1  out_data == 0
- out_sat  output  1  beat count saturated during frame

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - in_ready=0 while rst_n low; in_ready=1 from first clk edge after deassertion.
  - out_valid=0, out_data=0, out_count=0, out_zero=0, out_sat=0.
  - FSM in IDLE, accumulator cleared.
- Beat transfer: in_valid && in_ready at rising clk. Result transfer: out_valid && out_ready.
- FSM states: IDLE, ACCUM, HOLD.
  - IDLE, in_ready=1: on beat, latch op_q=in_op, acc=r, cnt=1, sat=0. If in_last, go to HOLD; else go to ACCUM.
  - ACCUM, in_ready=1: on beat, acc=acc OPR r, cnt=cnt+1 saturating (sat set when cnt would exceed max). If in_last, go to HOLD. in_op ignored in ACCUM; op_q is fixed for the frame.
  - HOLD, in_ready=0, out_valid=1: outputs stable until the transfer. On transfer, go to IDLE; in_ready returns 1 the following cycle (no same-cycle bypass).
- Per-beat result r:
  - AND: a&b; OR: a|b; XOR: a^b.
  - NAND: a&b internally, inverted at output (out_data = ~acc).
- Reduction operator OPR: AND and NAND reduce with &, OR with |, XOR with ^.
- Output registers:
  - out_data, out_count, out_zero, out_sat load on the transition into HOLD.
  - Latency: result valid exactly 1 cycle after the last beat is accepted.
  - out_zero is computed on the final (post-inversion) value.
- Single-beat frame (in_last on first beat): IDLE goes directly to HOLD with out_count=1.
- in_valid low mid-frame: state and accumulator hold; no timeout.
- Count saturation: cnt stops at 2^CNT_W-1; out_sat=1 for that frame; the data reduction continues correctly.
- out_ready high while not in HOLD: no effect.
- Reset mid-frame or in HOLD: immediate return to reset values; the partial frame is discarded.
- Unknown in_op: none possible; all 4 codes are defined.

Optional Feature:
- Macro: LRU_PARITY_EN.
- When defined: adds output out_parity (1 bit) = ^out_data, registered with out_data, reset 0, valid under out_valid.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then single beat op=00, a=8'hF0, b=8'h3C, last=1 -> next cycle out_valid=1, out_data=8'h30, out_count=1, out_zero=0; in_ready=0 until result taken.
- 3-beat frame op=10: (8'hFF,8'h0F), (8'h01,8'h00), (8'hAA,8'hAA) -> out_data=8'hF1, out_count=3, out_zero=0; in_op changed to 00 on beat 2 has no effect.
- op=11 frame: (8'hFF,8'hFF), (8'h0F,8'hFF) -> out_data=8'hF0; op=00 frame (8'h0F,8'hF0) -> out_data=8'h00, out_zero=1.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0, in_valid beats not accepted; release -> in_ready=1 one cycle after the transfer.
- CNT_W=2, 5-beat OR frame of a=1<<i, b=0 -> out_data=8'h1F, out_count=3, out_sat=1.
- Assert rst_n=0 mid-frame after 2 beats -> all outputs 0 immediately; next frame starts clean. With LRU_PARITY_EN defined, out_data=8'h30 gives out_parity=0 and 8'hF1 gives out_parity=1.

Source files
------------

// File: rtl/logic_reduce_unit.sv
// Framed bitwise AND/OR/XOR/NAND reducer with registered per-frame result.
// Optional LRU_PARITY_EN adds out_parity = ^out_data.
module logic_reduce_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_zero,
`ifdef LRU_PARITY_EN
  output logic             out_parity,
`endif
  output logic             out_sat
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             up_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic             beat, first, load;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] r, red, fold, res;

  assign in_ready  = up_q && (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign beat      = in_valid && in_ready;
  assign load      = beat && in_last;
  assign first     = (state_q == IDLE);
  // op is captured on the first beat and frozen for the rest of the frame
  assign op_sel    = first ? in_op : op_q;

  always_comb begin
    r   = in_a & in_b;
    red = acc_q & r;
    unique case (op_sel)
      2'b01: begin
        r   = in_a | in_b;
        red = acc_q | r;
      end
      2'b10: begin
        r   = in_a ^ in_b;
        red = acc_q ^ r;
      end
      default: ;
    endcase
    fold = first ? r : red;
    res  = (op_sel == 2'b11) ? ~fold : fold;
  end

  always_comb begin
    cnt_d = CNT_ONE;
    sat_d = 1'b0;
    if (!first) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
      sat_d = sat_q | (cnt_q == CNT_MAX);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (load)      state_d = HOLD;
        else if (beat) state_d = ACCUM;
      end
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      up_q      <= 1'b0;
      op_q      <= 2'b00;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_zero  <= 1'b0;
      out_sat   <= 1'b0;
`ifdef LRU_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else begin
      up_q    <= 1'b1;
      state_q <= state_d;
      if (beat) begin
        op_q  <= op_sel;
        acc_q <= fold;
        cnt_q <= cnt_d;
        sat_q <= sat_d;
      end
      if (load) begin
        out_data  <= res;
        out_count <= cnt_d;
        out_zero  <= (res == '0);
        out_sat   <= sat_d;
`ifdef LRU_PARITY_EN
        out_parity <= ^res;
`endif
      end
    end
  end

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Directed bench for logic_reduce_unit: default width plus a CNT_W=2 copy.
module tb_logic_reduce_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_last, out_ready;
  logic [7:0] in_a, in_b;
  logic [1:0] in_op;

  logic       rdy1, ov1, z1, s1;
  logic [7:0] d1, c1;
  logic       rdy2, ov2, z2, s2;
  logic [7:0] d2;
  logic [1:0] c2;
`ifdef LRU_PARITY_EN
  logic       p1, p2;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic_reduce_unit #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
    .out_valid(ov1), .out_ready(out_ready),
    .out_data(d1), .out_count(c1), .out_zero(z1),
`ifdef LRU_PARITY_EN
    .out_parity(p1),
`endif
    .out_sat(s1)
  );

  logic_reduce_unit #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(rdy2),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_last(in_last),
    .out_valid(ov2), .out_ready(out_ready),
    .out_data(d2), .out_count(c2), .out_zero(z2),
`ifdef LRU_PARITY_EN
    .out_parity(p2),
`endif
    .out_sat(s2)
  );

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ov_after_take", {31'b0, ov1}, 32'd0);
    check("rdy_after_take", {31'b0, rdy1}, 32'd1);
  endtask

  typedef struct {
    logic [1:0]      op;
    int              n;
    logic [4:0][7:0] a;
    logic [4:0][7:0] b;
    logic [7:0]      d;
    int              cnt1;
    int              cnt2;
    logic            sat2;
    logic            z;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{2'd0, 1, {8'h00, 8'h00, 8'h00, 8'h00, 8'hF0},
              {8'h00, 8'h00, 8'h00, 8'h00, 8'h3C}, 8'h30, 1, 1, 1'b0, 1'b0};
    vt[1] = '{2'd2, 3, {8'h00, 8'h00, 8'hAA, 8'h01, 8'hFF},
              {8'h00, 8'h00, 8'hAA, 8'h00, 8'h0F}, 8'hF1, 3, 3, 1'b0, 1'b0};
    vt[2] = '{2'd3, 2, {8'h00, 8'h00, 8'h00, 8'h0F, 8'hFF},
              {8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF}, 8'hF0, 2, 2, 1'b0, 1'b0};
    vt[3] = '{2'd0, 1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h0F},
              {8'h00, 8'h00, 8'h00, 8'h00, 8'hF0}, 8'h00, 1, 1, 1'b0, 1'b1};
    vt[4] = '{2'd1, 5, {8'h10, 8'h08, 8'h04, 8'h02, 8'h01},
              {8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h1F, 5, 3, 1'b1, 1'b0};
    vt[5] = '{2'd3, 1, {8'h00, 8'h00, 8'h00, 8'h00, 8'hFF},
              {8'h00, 8'h00, 8'h00, 8'h00, 8'hFF}, 8'h00, 1, 1, 1'b0, 1'b1};

    rst_n = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;
    #22;
    check("rst_rdy", {31'b0, rdy1}, 32'd0);
    check("rst_ov", {31'b0, ov1}, 32'd0);
    check("rst_data", {24'b0, d1}, 32'd0);
    check("rst_cnt", {24'b0, c1}, 32'd0);
    check("rst_zero", {31'b0, z1}, 32'd0);
    check("rst_sat", {31'b0, s1}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", {31'b0, rdy1}, 32'd0);
    tick();
    check("rdy_after_edge", {31'b0, rdy1}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < vt[i].n; j++) begin
        logic [1:0] op;
        op = (j == 0) ? vt[i].op : ((vt[i].op == 2'd0) ? 2'd3 : 2'd0);
        check($sformatf("v%0d_rdy_b%0d", i, j), {31'b0, rdy1}, 32'd1);
        check($sformatf("v%0d_ov_b%0d", i, j), {31'b0, ov1}, 32'd0);
        beat(op, vt[i].a[j], vt[i].b[j], j == vt[i].n - 1);
        if (j == 0 && vt[i].n > 1) begin
          tick();
          tick();
        end
      end
      check($sformatf("v%0d_ov", i), {31'b0, ov1}, 32'd1);
      check($sformatf("v%0d_rdy", i), {31'b0, rdy1}, 32'd0);
      check($sformatf("v%0d_data", i), {24'b0, d1}, {24'b0, vt[i].d});
      check($sformatf("v%0d_cnt", i), {24'b0, c1}, vt[i].cnt1);
      check($sformatf("v%0d_zero", i), {31'b0, z1}, {31'b0, vt[i].z});
      check($sformatf("v%0d_sat", i), {31'b0, s1}, 32'd0);
      check($sformatf("v%0d_d2", i), {24'b0, d2}, {24'b0, vt[i].d});
      check($sformatf("v%0d_c2", i), {30'b0, c2}, vt[i].cnt2);
      check($sformatf("v%0d_s2", i), {31'b0, s2}, {31'b0, vt[i].sat2});
`ifdef LRU_PARITY_EN
      check($sformatf("v%0d_par", i), {31'b0, p1}, {31'b0, ^vt[i].d});
`endif
      take();
    end

    beat(2'd1, 8'h55, 8'hAA, 1'b1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_last = 1'b1; in_op = 2'd0;
      in_a = 8'h00; in_b = 8'h00;
      tick();
      check($sformatf("bp_ov%0d", k), {31'b0, ov1}, 32'd1);
      check($sformatf("bp_rdy%0d", k), {31'b0, rdy1}, 32'd0);
      check($sformatf("bp_data%0d", k), {24'b0, d1}, 32'hFF);
      check($sformatf("bp_cnt%0d", k), {24'b0, c1}, 32'd1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    take();
    tick();
    check("bp_no_extra", {31'b0, ov1}, 32'd0);

    beat(2'd0, 8'hFF, 8'hFF, 1'b0);
    beat(2'd0, 8'hFF, 8'hFF, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdy", {31'b0, rdy1}, 32'd0);
    check("mid_rst_data", {24'b0, d1}, 32'd0);
    check("mid_rst_cnt", {24'b0, c1}, 32'd0);
    check("mid_rst_ov", {31'b0, ov1}, 32'd0);
    #10;
    rst_n = 1'b1;
    tick();
    beat(2'd1, 8'h0F, 8'h00, 1'b1);
    check("post_rst_ov", {31'b0, ov1}, 32'd1);
    check("post_rst_data", {24'b0, d1}, 32'h0F);
    check("post_rst_cnt", {24'b0, c1}, 32'd1);
    check("post_rst_c2", {30'b0, c2}, 32'd1);
    take();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
